// File: rtl/oflow_mem_buffer_ctrl_pkg.sv
// Shared types and constants for the frame-history buffer controller.
package oflow_mem_buffer_ctrl_pkg;

    localparam int FRAME_NUM_WIDTH = 8;
    localparam int HIST_WIDTH      = 3;
    localparam int OFFSET_WIDTH    = 7;
    localparam int MEM_DEPTH       = 128;
    // Write pointer must hold values up to MEM_DEPTH itself (region fully used).
    localparam int PTR_WIDTH       = 8;

    localparam logic [HIST_WIDTH-1:0] MAX_HIST = HIST_WIDTH'(5);

    typedef enum logic [1:0] {
        S_UNCFG = 2'd0,
        S_READY = 2'd1,
        S_FRAME = 2'd2
    } state_t;

    // Entries available to one frame when the buffer is split into n regions.
    function automatic logic [PTR_WIDTH-1:0] region_size(input logic [HIST_WIDTH-1:0] n);
        case (n)
            3'd1:    return PTR_WIDTH'(MEM_DEPTH);
            3'd2:    return PTR_WIDTH'(MEM_DEPTH / 2);
            3'd3:    return 8'd42;
            3'd4:    return PTR_WIDTH'(MEM_DEPTH / 4);
            3'd5:    return 8'd25;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/oflow_mem_buffer_ctrl_if.sv
// Requester handshakes, configuration and buffer pins of the controller.
//
// Handshake: a requester raises wr_valid / rd_req and holds its payload
// stable; the transfer happens in any cycle where the matching wr_ready /
// rd_ready is high at the clock edge. Ready is a combinational grant, never
// both in one cycle, and may depend on the request.
interface oflow_mem_buffer_ctrl_if;
    import oflow_mem_buffer_ctrl_pkg::*;

    logic                       cfg_load;
    logic [HIST_WIDTH-1:0]      cfg_hist;
    logic                       cfg_err;
    logic                       frame_start;
    logic                       wr_valid;
    logic                       wr_single;
    logic                       wr_last;
    logic                       wr_ready;
    logic                       wr_ovf;
    logic                       rd_req;
    logic [HIST_WIDTH-1:0]      rd_hist_idx;
    logic [OFFSET_WIDTH-1:0]    rd_offset_0;
    logic [OFFSET_WIDTH-1:0]    rd_offset_1;
    logic                       rd_dual;
    logic                       rd_ready;
    logic                       rd_err;
    logic                       rd_rvalid;
    logic [FRAME_NUM_WIDTH-1:0] mem_frame_num;
    logic [HIST_WIDTH-1:0]      mem_hist;
    logic [OFFSET_WIDTH-1:0]    mem_offset_0;
    logic [OFFSET_WIDTH-1:0]    mem_offset_1;
    logic                       mem_csb_0;
    logic                       mem_csb_1;
    logic                       mem_we;
    logic                       mem_oeb;
    logic [FRAME_NUM_WIDTH-1:0] cur_frame;
    state_t                     state;

    modport slave (
        input  cfg_load, cfg_hist, frame_start, wr_valid, wr_single, wr_last,
               rd_req, rd_hist_idx, rd_offset_0, rd_offset_1, rd_dual,
        output cfg_err, wr_ready, wr_ovf, rd_ready, rd_err, rd_rvalid,
               mem_frame_num, mem_hist, mem_offset_0, mem_offset_1,
               mem_csb_0, mem_csb_1, mem_we, mem_oeb, cur_frame, state
    );

    modport master (
        output cfg_load, cfg_hist, frame_start, wr_valid, wr_single, wr_last,
               rd_req, rd_hist_idx, rd_offset_0, rd_offset_1, rd_dual,
        input  cfg_err, wr_ready, wr_ovf, rd_ready, rd_err, rd_rvalid,
               mem_frame_num, mem_hist, mem_offset_0, mem_offset_1,
               mem_csb_0, mem_csb_1, mem_we, mem_oeb, cur_frame, state
    );

endinterface

// File: rtl/oflow_mem_rr_arbiter.sv
// Two-requester round-robin arbiter; the requester not served last wins ties.
module oflow_mem_rr_arbiter (
    input  logic clk,
    input  logic reset_N,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    // 1 = writer was granted most recently, 0 = reader (reset value).
    logic last_wr_q;

    // Grant the sole requester, or on contention the one not served last.
    always_comb begin
        gnt_wr = req_wr && (!req_rd || !last_wr_q);
        gnt_rd = req_rd && !gnt_wr;
    end

    // Remember who was served so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (!reset_N)    last_wr_q <= 1'b0;
        else if (gnt_wr) last_wr_q <= 1'b1;
        else if (gnt_rd) last_wr_q <= 1'b0;
    end

endmodule

// File: rtl/oflow_mem_buffer_ctrl.sv
// Frame-history buffer controller: frame counter, write offsets, overflow,
// history validity and read/write sharing of the two-port buffer.
module oflow_mem_buffer_ctrl
    import oflow_mem_buffer_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_N,
    oflow_mem_buffer_ctrl_if.slave  bus
);

    state_t                     state_q, state_d;
    logic [HIST_WIDTH-1:0]      n_q;
    logic [HIST_WIDTH-1:0]      hist_valid_q;
    logic [FRAME_NUM_WIDTH-1:0] cur_frame_q;
    logic [PTR_WIDTH-1:0]       wr_ptr_q;
    logic                       rd_pend_q;

    logic gnt_wr, gnt_rd;
    logic cfg_ok, cfg_take, cfg_rej, open_frame, close_frame;
    logic wr_fit, rd_ok;
    logic [PTR_WIDTH-1:0] wr_k;

    assign cfg_ok      = (bus.cfg_hist >= HIST_WIDTH'(1)) && (bus.cfg_hist <= MAX_HIST);
    assign wr_k        = bus.wr_single ? PTR_WIDTH'(1) : PTR_WIDTH'(2);
    assign wr_fit      = (wr_ptr_q + wr_k) <= region_size(n_q);
    assign rd_ok       = bus.rd_hist_idx <= hist_valid_q;
    assign close_frame = gnt_wr && bus.wr_last;

    oflow_mem_rr_arbiter u_arb (
        .clk     (clk),
        .reset_N (reset_N),
        .req_wr  (bus.wr_valid && (state_q == S_FRAME)),
        .req_rd  (bus.rd_req && (state_q != S_UNCFG)),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd)
    );

    assign bus.wr_ready  = gnt_wr;
    assign bus.rd_ready  = gnt_rd;
    assign bus.mem_hist  = n_q;
    assign bus.cur_frame = cur_frame_q;
    assign bus.state     = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_N) state_q <= S_UNCFG;
        else          state_q <= state_d;
    end

    // Next state from the decoded control events.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_UNCFG: if (cfg_take)    state_d = S_READY;
            S_READY: if (open_frame)  state_d = S_FRAME;
            S_FRAME: if (close_frame) state_d = S_READY;
            default:                  state_d = S_UNCFG;
        endcase
    end

    // Control events per state; cfg_load takes precedence over frame_start.
    always_comb begin
        cfg_take   = 1'b0;
        cfg_rej    = 1'b0;
        open_frame = 1'b0;
        case (state_q)
            S_UNCFG, S_READY: begin
                if (bus.cfg_load) begin
                    cfg_take = cfg_ok;
                    cfg_rej  = !cfg_ok;
                end else if (state_q == S_READY && bus.frame_start) begin
                    open_frame = 1'b1;
                end
            end
            S_FRAME: cfg_rej = bus.cfg_load;
            default: ;
        endcase
    end

    // Frame counter, write pointer, overflow and history-validity tracking.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            n_q          <= '0;
            hist_valid_q <= '0;
            cur_frame_q  <= '0;
            wr_ptr_q     <= '0;
            bus.wr_ovf   <= 1'b0;
        end else begin
            if (cfg_take) begin
                n_q          <= bus.cfg_hist;
                hist_valid_q <= '0;
                cur_frame_q  <= '0;
            end
            if (open_frame) begin
                wr_ptr_q   <= '0;
                bus.wr_ovf <= 1'b0;
            end
            if (gnt_wr) begin
                if (wr_fit) wr_ptr_q   <= wr_ptr_q + wr_k;
                else        bus.wr_ovf <= 1'b1;
                if (bus.wr_last) begin
                    cur_frame_q <= cur_frame_q + FRAME_NUM_WIDTH'(1);
                    // frame_num mod N jumps at the 255->0 wrap, so history restarts.
                    if (cur_frame_q == '1)
                        hist_valid_q <= '0;
                    else if (hist_valid_q + HIST_WIDTH'(1) >= n_q)
                        hist_valid_q <= n_q - HIST_WIDTH'(1);
                    else
                        hist_valid_q <= hist_valid_q + HIST_WIDTH'(1);
                end
            end
        end
    end

    // Registered buffer pins and response pulses; idle unless a grant is taken.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            bus.mem_frame_num <= '0;
            bus.mem_offset_0  <= '0;
            bus.mem_offset_1  <= '0;
            bus.mem_csb_0     <= 1'b1;
            bus.mem_csb_1     <= 1'b1;
            bus.mem_we        <= 1'b0;
            bus.mem_oeb       <= 1'b1;
            bus.rd_err        <= 1'b0;
            bus.rd_rvalid     <= 1'b0;
            bus.cfg_err       <= 1'b0;
            rd_pend_q         <= 1'b0;
        end else begin
            bus.mem_csb_0 <= 1'b1;
            bus.mem_csb_1 <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_oeb   <= 1'b1;
            bus.rd_err    <= 1'b0;
            bus.cfg_err   <= cfg_rej;
            rd_pend_q     <= 1'b0;
            bus.rd_rvalid <= rd_pend_q;
            if (gnt_wr && wr_fit) begin
                bus.mem_frame_num <= cur_frame_q;
                bus.mem_offset_0  <= wr_ptr_q[OFFSET_WIDTH-1:0];
                bus.mem_offset_1  <= wr_ptr_q[OFFSET_WIDTH-1:0] + OFFSET_WIDTH'(1);
                bus.mem_csb_0     <= 1'b0;
                bus.mem_csb_1     <= bus.wr_single;
                bus.mem_we        <= 1'b1;
            end else if (gnt_rd) begin
                if (rd_ok) begin
                    bus.mem_frame_num <= cur_frame_q - FRAME_NUM_WIDTH'(bus.rd_hist_idx);
                    bus.mem_offset_0  <= bus.rd_offset_0;
                    bus.mem_offset_1  <= bus.rd_offset_1;
                    bus.mem_csb_0     <= 1'b0;
                    bus.mem_csb_1     <= !bus.rd_dual;
                    bus.mem_oeb       <= 1'b0;
                    rd_pend_q         <= 1'b1;
                end else begin
                    bus.rd_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_oflow_mem_buffer_ctrl.sv
// Self-checking bench for oflow_mem_buffer_ctrl with a frame-level model.
module tb_oflow_mem_buffer_ctrl;
    import oflow_mem_buffer_ctrl_pkg::*;

    logic clk;
    logic reset_N;
    oflow_mem_buffer_ctrl_if bus ();

    oflow_mem_buffer_ctrl dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: configuration, frame counter, fill level, history depth.
    int     n_m, cur_m, ptr_m, hv_m;
    bit     ovf_m, lg_wr_m;
    state_t st_m;
    int     r_tab [0:5] = '{0, 128, 64, 42, 32, 25};
    logic   exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        n_m = 0; cur_m = 0; ptr_m = 0; hv_m = 0;
        ovf_m = 0; lg_wr_m = 0; st_m = S_UNCFG;
    endtask

    task automatic frame_done();
        cur_m = (cur_m + 1) % 256;
        if (cur_m == 0) hv_m = 0;
        else hv_m = (hv_m + 1 < n_m - 1) ? hv_m + 1 : n_m - 1;
        st_m = S_READY;
    endtask

    task automatic do_cfg(input int v);
        bit acc;
        acc = (st_m != S_FRAME) && (v >= 1) && (v <= 5);
        bus.cfg_load = 1'b1;
        bus.cfg_hist = 3'(v);
        tick();
        bus.cfg_load = 1'b0;
        if (acc) begin
            n_m = v; hv_m = 0; cur_m = 0; st_m = S_READY;
        end
        vectors++;
        if (bus.cfg_err !== !acc || bus.state !== st_m || bus.mem_hist !== 3'(n_m) || bus.cur_frame !== 8'(cur_m)) begin
            miscompares++;
            $display("FAIL cfg(%0d): err=%b state=%0d hist=%0d cur=%0d, required err=%b state=%0d hist=%0d cur=%0d",
                     v, bus.cfg_err, bus.state, bus.mem_hist, bus.cur_frame, !acc, st_m, n_m, cur_m);
        end
        tick();
        vectors++;
        if (bus.cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_err_pulse: got %b, required 0", bus.cfg_err);
        end
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        if (st_m == S_READY) begin
            st_m = S_FRAME; ptr_m = 0; ovf_m = 0;
        end
        vectors++;
        if (bus.state !== st_m || bus.wr_ovf !== ovf_m) begin
            miscompares++;
            $display("FAIL frame_start: state=%0d ovf=%b, required state=%0d ovf=%b",
                     bus.state, bus.wr_ovf, st_m, ovf_m);
        end
    endtask

    task automatic write_one(input bit single, input bit last);
        int k;
        bit fit;
        bus.wr_valid  = 1'b1;
        bus.wr_single = single;
        bus.wr_last   = last;
        #1;
        vectors++;
        if ({bus.wr_ready, bus.rd_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_grant: wr_ready=%b rd_ready=%b, required 1 0", bus.wr_ready, bus.rd_ready);
        end
        k = single ? 1 : 2;
        fit = (ptr_m + k <= r_tab[n_m]);
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        vectors++;
        if (fit) begin
            if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb} !== {1'b0, single, 2'b11} ||
                bus.mem_offset_0 !== 7'(ptr_m) || bus.mem_offset_1 !== 7'(ptr_m + 1) ||
                bus.mem_frame_num !== 8'(cur_m)) begin
                miscompares++;
                $display("FAIL wr_access: csb=%b%b we=%b oeb=%b off=%0d/%0d fn=%0d, required csb=0%b we=1 oeb=1 off=%0d/%0d fn=%0d",
                         bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.mem_offset_0,
                         bus.mem_offset_1, bus.mem_frame_num, single, ptr_m % 128, (ptr_m + 1) % 128, cur_m);
            end
            ptr_m += k;
        end else begin
            ovf_m = 1;
            if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we} !== 3'b110) begin
                miscompares++;
                $display("FAIL wr_drop: csb=%b%b we=%b, required csb=11 we=0",
                         bus.mem_csb_0, bus.mem_csb_1, bus.mem_we);
            end
        end
        lg_wr_m = 1;
        if (last) frame_done();
        vectors++;
        if (bus.wr_ovf !== ovf_m || bus.cur_frame !== 8'(cur_m) || bus.state !== st_m) begin
            miscompares++;
            $display("FAIL wr_status: ovf=%b cur=%0d state=%0d, required ovf=%b cur=%0d state=%0d",
                     bus.wr_ovf, bus.cur_frame, bus.state, ovf_m, cur_m, st_m);
        end
    endtask

    task automatic read_one(input int idx, input int o0, input int o1, input bit dual);
        bit ok;
        bus.rd_req      = 1'b1;
        bus.rd_hist_idx = 3'(idx);
        bus.rd_offset_0 = 7'(o0);
        bus.rd_offset_1 = 7'(o1);
        bus.rd_dual     = dual;
        #1;
        vectors++;
        if ({bus.wr_ready, bus.rd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_grant: wr_ready=%b rd_ready=%b, required 0 1", bus.wr_ready, bus.rd_ready);
        end
        ok = (idx <= hv_m);
        tick();
        bus.rd_req = 1'b0;
        lg_wr_m = 0;
        vectors++;
        if (ok) begin
            if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.rd_err} !== {1'b0, !dual, 3'b000} ||
                bus.mem_frame_num !== 8'((cur_m - idx + 256) % 256) ||
                bus.mem_offset_0 !== 7'(o0) || bus.mem_offset_1 !== 7'(o1)) begin
                miscompares++;
                $display("FAIL rd_access(idx %0d): csb=%b%b we=%b oeb=%b err=%b fn=%0d off=%0d/%0d, required csb=0%b we=0 oeb=0 err=0 fn=%0d off=%0d/%0d",
                         idx, bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.rd_err,
                         bus.mem_frame_num, bus.mem_offset_0, bus.mem_offset_1, !dual,
                         (cur_m - idx + 256) % 256, o0, o1);
            end
        end else begin
            if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.rd_err} !== 5'b11011) begin
                miscompares++;
                $display("FAIL rd_reject(idx %0d): csb=%b%b we=%b oeb=%b err=%b, required csb=11 we=0 oeb=1 err=1",
                         idx, bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.rd_err);
            end
        end
        tick();
        vectors++;
        if (bus.rd_rvalid !== ok || bus.rd_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_rvalid(idx %0d): rvalid=%b err=%b, required rvalid=%b err=0",
                     idx, bus.rd_rvalid, bus.rd_err, ok);
        end
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        repeat (3) tick();
        model_reset();
        vectors++;
        if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb} !== 4'b1101 ||
            bus.mem_offset_0 !== 7'd0 || bus.mem_offset_1 !== 7'd0 || bus.mem_hist !== 3'd0 ||
            bus.cur_frame !== 8'd0 || bus.state !== S_UNCFG ||
            {bus.wr_ready, bus.rd_ready, bus.rd_err, bus.rd_rvalid, bus.cfg_err, bus.wr_ovf} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset: csb=%b%b we=%b oeb=%b hist=%0d cur=%0d state=%0d flags=%b%b%b%b%b%b, required idle pins, zeros, state 0",
                     bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.mem_hist, bus.cur_frame,
                     bus.state, bus.wr_ready, bus.rd_ready, bus.rd_err, bus.rd_rvalid, bus.cfg_err, bus.wr_ovf);
        end
        reset_N = 1'b1;
        tick();
        bus.rd_req = 1'b1;
        #1;
        vectors++;
        if (bus.rd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_unconfigured: rd_ready=%b, required 0", bus.rd_ready);
        end
        bus.rd_req = 1'b0;
        tick();
    endtask

    task automatic test_cfg();
        do_cfg(6);
        do_cfg(0);
        do_cfg(3);
    endtask

    task automatic test_write_n4();
        do_cfg(4);
        start_frame();
        for (int i = 0; i < 16; i++) write_one(1'b0, i == 15);
    endtask

    task automatic test_overflow_n5();
        do_cfg(5);
        start_frame();
        for (int i = 0; i < 13; i++) write_one(1'b0, 1'b0);
        start_frame();
        do_cfg(2);
        write_one(1'b1, 1'b1);
        start_frame();
        write_one(1'b1, 1'b1);
    endtask

    task automatic test_read_n3();
        do_cfg(3);
        for (int f = 0; f < 2; f++) begin
            start_frame();
            write_one(1'b1, 1'b1);
        end
        start_frame();
        read_one(2, 10, 11, 1'b1);
        read_one(3, 4, 5, 1'b0);
        read_one(0, 0, 127, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int i = 0; i <= 8; i++) begin
            ok = 1'b0;
            if (i < 8) begin
                bus.rd_req      = 1'b1;
                bus.rd_hist_idx = 3'($urandom_range(0, hv_m + 1));
                bus.rd_offset_0 = 7'($urandom_range(0, 127));
                bus.rd_offset_1 = 7'($urandom_range(0, 127));
                bus.rd_dual     = 1'($urandom_range(0, 1));
                ok = (int'(bus.rd_hist_idx) <= hv_m);
                #1;
                vectors++;
                if (bus.rd_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_grant[%0d]: rd_ready=%b, required 1", i, bus.rd_ready);
                end
            end else begin
                bus.rd_req = 1'b0;
            end
            tick();
            if (i < 8) begin
                vectors++;
                if ({bus.mem_oeb, bus.rd_err} !== {!ok, !ok} ||
                    (ok && bus.mem_frame_num !== 8'((cur_m - int'(bus.rd_hist_idx) + 256) % 256))) begin
                    miscompares++;
                    $display("FAIL b2b_access[%0d]: oeb=%b err=%b fn=%0d, required oeb=%b err=%b",
                             i, bus.mem_oeb, bus.rd_err, bus.mem_frame_num, !ok, !ok);
                end
                lg_wr_m = 0;
            end
            vectors++;
            if (i == 0) begin
                if (bus.rd_rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_rvalid[0]: got %b, required 0", bus.rd_rvalid);
                end
            end else begin
                if (bus.rd_rvalid !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_rvalid[%0d]: got %b, required %b", i, bus.rd_rvalid, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            if (i < 8) exp_q.push_back(ok);
        end
        tick();
    endtask

    task automatic test_contention();
        bit exp_w, fit;
        bus.wr_valid    = 1'b1;
        bus.wr_single   = 1'b0;
        bus.wr_last     = 1'b0;
        bus.rd_req      = 1'b1;
        bus.rd_hist_idx = 3'd0;
        bus.rd_offset_0 = 7'd5;
        bus.rd_offset_1 = 7'd6;
        bus.rd_dual     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_w = !lg_wr_m;
            vectors++;
            if ({bus.wr_ready, bus.rd_ready} !== {exp_w, !exp_w}) begin
                miscompares++;
                $display("FAIL contention[%0d]: wr_ready=%b rd_ready=%b, required %b %b",
                         c, bus.wr_ready, bus.rd_ready, exp_w, !exp_w);
            end
            fit = exp_w && (ptr_m + 2 <= r_tab[n_m]);
            tick();
            if (exp_w) begin
                if (fit) ptr_m += 2; else ovf_m = 1;
            end
            lg_wr_m = exp_w;
            vectors++;
            if ({bus.mem_we, bus.mem_oeb} !== {fit, exp_w}) begin
                miscompares++;
                $display("FAIL contention_pins[%0d]: we=%b oeb=%b, required we=%b oeb=%b",
                         c, bus.mem_we, bus.mem_oeb, fit, exp_w);
            end
        end
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        tick();
        tick();
        write_one(1'b0, 1'b1);
    endtask

    task automatic test_random_frames();
        int nw;
        for (int c = 0; c < 5; c++) begin
            do_cfg($urandom_range(1, 5));
            for (int f = 0; f < 3; f++) begin
                start_frame();
                nw = $urandom_range(1, 40);
                for (int w = 0; w < nw; w++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        tick();
                        vectors++;
                        if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb} !== 4'b1101) begin
                            miscompares++;
                            $display("FAIL idle: csb=%b%b we=%b oeb=%b, required 11 0 1",
                                     bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb);
                        end
                    end
                    write_one(1'($urandom_range(0, 1)), w == nw - 1);
                end
                read_one($urandom_range(0, hv_m + 1), $urandom_range(0, 127),
                         $urandom_range(0, 127), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic test_wrap();
        do_cfg(5);
        while (cur_m != 255) begin
            start_frame();
            write_one(1'b1, 1'b1);
        end
        read_one(4, 1, 2, 1'b0);
        start_frame();
        write_one(1'b1, 1'b1);
        read_one(1, 3, 4, 1'b0);
        read_one(0, 3, 4, 1'b1);
    endtask

    task automatic test_reset_in_flight();
        start_frame();
        bus.wr_valid = 1'b1;
        bus.wr_last  = 1'b1;
        reset_N      = 1'b0;
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        reset_N      = 1'b1;
        model_reset();
        vectors++;
        if ({bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb} !== 4'b1101 ||
            bus.state !== S_UNCFG || bus.cur_frame !== 8'd0 || bus.mem_hist !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_in_flight: csb=%b%b we=%b oeb=%b state=%0d cur=%0d hist=%0d, required idle, 0, 0, 0",
                     bus.mem_csb_0, bus.mem_csb_1, bus.mem_we, bus.mem_oeb, bus.state, bus.cur_frame, bus.mem_hist);
        end
    endtask

    initial begin
        reset_N         = 1'b0;
        bus.cfg_load    = 1'b0;
        bus.cfg_hist    = '0;
        bus.frame_start = 1'b0;
        bus.wr_valid    = 1'b0;
        bus.wr_single   = 1'b0;
        bus.wr_last     = 1'b0;
        bus.rd_req      = 1'b0;
        bus.rd_hist_idx = '0;
        bus.rd_offset_0 = '0;
        bus.rd_offset_1 = '0;
        bus.rd_dual     = 1'b0;
        test_reset();
        test_cfg();
        test_write_n4();
        test_overflow_n5();
        test_read_n3();
        test_back_to_back();
        test_contention();
        test_random_frames();
        test_wrap();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oflow_mem_buffer_ctrl.md
Name: oflow_mem_buffer_ctrl

Overview:
- Sequences and shares the two-port frame-history memory buffer between two requesters:
  - the feature-extraction writer, which stores current-frame objects;
  - the scoring reader, which fetches objects of current or past frames.
- Owns the frame counter, the per-frame write offset, region-overflow checks, history-validity tracking and write/read arbitration.
- Drives the buffer's frame_num, num_of_history_frames, offset_0/1, csb_0/1, we and oeb pins.

Parameters:
- FRAME_NUM_WIDTH, 8, width of frame counter (wraps 255->0).
- HIST_WIDTH, 3, width of history-frame count.
- MAX_HIST, 5, max configurable history frames.
- OFFSET_WIDTH, 7, offset within a frame region.
- MEM_DEPTH, 128, total buffer entries.

Ports:
- clk  in  1  clock.
- reset_N  in  1  synchronous, active-low reset.
- cfg_load  in  1  pulse: load cfg_hist.
- cfg_hist  in  HIST_WIDTH  number of history frames N, 1..5.
- cfg_err  out  1  one-cycle pulse on a rejected config.
- frame_start  in  1  pulse: open a new write frame.
- wr_valid  in  1  write request.
- wr_single  in  1  1 = write one object (port 0 only); 0 = write two.
- wr_last  in  1  marks the last write of the frame.
- wr_ready  out  1  write accepted this cycle.
- wr_ovf  out  1  sticky region-overflow flag; cleared at frame_start.
- rd_req  in  1  read request.
- rd_hist_idx  in  HIST_WIDTH  frames back (0 = current frame).
- rd_offset_0  in  OFFSET_WIDTH  read offset, port 0.
- rd_offset_1  in  OFFSET_WIDTH  read offset, port 1.
- rd_dual  in  1  also read port 1.
- rd_ready  out  1  read accepted this cycle.
- rd_err  out  1  pulse: read rejected (index invalid).
- rd_rvalid  out  1  buffer data_out valid.
- mem_frame_num  out  FRAME_NUM_WIDTH  frame_num to buffer.
- mem_hist  out  HIST_WIDTH  num_of_history_frames to buffer.
- mem_offset_0  out  OFFSET_WIDTH  offset to buffer, port 0.
- mem_offset_1  out  OFFSET_WIDTH  offset to buffer, port 1.
- mem_csb_0  out  1  chip select, active low, port 0.
- mem_csb_1  out  1  chip select, active low, port 1.
- mem_we  out  1  write enable, active high.
- mem_oeb  out  1  output enable, active low.
- cur_frame  out  FRAME_NUM_WIDTH  current frame number.

Behaviour:
- Reset (synchronous, reset_N=0 at a posedge) clears all state, with or without an operation in flight:
  - state = S_UNCFG, cur_frame = 0, wr_ptr = 0, hist_valid = 0, last_grant = rd;
  - mem_csb_0 = mem_csb_1 = 1, mem_we = 0, mem_oeb = 1, offsets = 0, mem_hist = 0;
  - wr_ready, rd_ready, rd_err, rd_rvalid, cfg_err, wr_ovf = 0.
- FSM states: S_UNCFG, S_READY, S_FRAME.
  - S_UNCFG: cfg_load with 1<=cfg_hist<=5 latches N -> S_READY. Any other cfg_hist -> cfg_err pulse, state unchanged.
  - S_READY: cfg_load accepted as above, reloads N and clears hist_valid and cur_frame; frame_start -> S_FRAME with wr_ptr = 0 and wr_ovf cleared.
  - S_FRAME: cfg_load rejected with a cfg_err pulse; an accepted write with wr_last=1 -> S_READY.
- Region size R(N), from a constant LUT: 1->128, 2->64, 3->42, 4->32, 5->25.
- Arbitration:
  - Writes are eligible only in S_FRAME. Reads are eligible in S_READY and S_FRAME.
  - Both eligible: round-robin on last_grant. Otherwise the sole eligible requester wins.
  - wr_ready and rd_ready are combinational grants, at most one per cycle.
- Write accepted at cycle t:
  - k = 1 if wr_single, else 2.
  - If wr_ptr + k <= R(N), at t+1 (registered): mem_frame_num = cur_frame, offset_0 = wr_ptr, offset_1 = wr_ptr+1, csb_0 = 0, csb_1 = wr_single, we = 1, oeb = 1. Then wr_ptr += k.
  - Otherwise the write is dropped: csb stays 1, wr_ovf is set, and wr_ready is still given.
- wr_last accepted:
  - cur_frame increments, wrapping 255->0.
  - hist_valid = min(hist_valid+1, N-1).
  - At wrap to 0, hist_valid is forced to 0, because the slot mapping (frame_num mod N) is discontinuous for N=3 and N=5.
- Read accepted at cycle t:
  - Valid iff rd_hist_idx <= hist_valid (idx 0 = current frame).
  - If valid, at t+1: mem_frame_num = cur_frame - rd_hist_idx (mod 256), offsets = rd_offset_0/1, csb_0 = 0, csb_1 = ~rd_dual, we = 0, oeb = 0. rd_rvalid = 1 at t+2.
  - If invalid: rd_err pulses at t+1, no memory access, rd_ready still given.
- Idle cycles: csb_0 = csb_1 = 1, we = 0, oeb = 1.
- mem_hist follows the latched N.
- cur_frame exposes the frame counter.
- Back-to-back reads are sustained at 1 per cycle, with rd_rvalid pipelined.
- frame_start while in S_FRAME is ignored.

Decomposition:
- Package oflow_mem_buffer_ctrl_pkg holds:
  - state enum;
  - region-size LUT function region_size(N);
  - MAX_HIST and MEM_DEPTH constants.
- Sub-module oflow_mem_rr_arbiter: 2-requester round-robin with a last_grant register.

Test Plan:
- Reset, cfg_load with cfg_hist=6 -> cfg_err=1, state stays S_UNCFG. Then cfg_hist=3 -> mem_hist=3, S_READY.
- N=4, frame_start, 16 dual writes then wr_last -> offsets 0..30 step 2, mem_we=1, cur_frame=1, no wr_ovf.
- N=5, 13 dual writes -> the 13th (wr_ptr=24, 24+2>25) is dropped, csb=1, wr_ovf=1. A following frame_start clears wr_ovf.
- N=3, frame 2 active, rd_hist_idx=2 -> mem_frame_num=0, oeb=0, rd_rvalid at t+2. rd_hist_idx=3 -> rd_err, no access.
- wr_valid and rd_req held high together for 6 cycles -> grants alternate wr/rd/wr..., never two in the same cycle.
- N=5, advance to frame 255 then wr_last -> cur_frame=0, hist_valid=0. rd_hist_idx=1 -> rd_err.
